// File: rtl/edge_pkg.sv
// Shared types and constants for the edge-to-level reconstructor.
// Stats widths are only consumed when EDGE_TO_LEVEL_STATS_EN is defined.
package edge_pkg;

   typedef enum logic [1:0] {
      S_LOW       = 2'd0,
      S_LOW_HOLD  = 2'd1,
      S_HIGH      = 2'd2,
      S_HIGH_HOLD = 2'd3
   } state_t;

   localparam logic LVL_LOW  = 1'b0;
   localparam logic LVL_HIGH = 1'b1;

   localparam int STAT_CHANGE_W = 16;
   localparam int STAT_ERR_W    = 8;

   function automatic logic is_hold(input state_t s);
      return (s == S_LOW_HOLD) || (s == S_HIGH_HOLD);
   endfunction

   function automatic logic level_of(input state_t s);
      return ((s == S_HIGH) || (s == S_HIGH_HOLD)) ? LVL_HIGH : LVL_LOW;
   endfunction

   function automatic state_t hold_state(input logic lvl);
      return (lvl == LVL_HIGH) ? S_HIGH_HOLD : S_LOW_HOLD;
   endfunction

   function automatic state_t stable_state(input logic lvl);
      return (lvl == LVL_HIGH) ? S_HIGH : S_LOW;
   endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that times the minimum hold window.
// Load wins over decrement; the count parks at zero.
module hold_timer #(
   parameter int CW = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          en,
   output logic          expired
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/edge_to_level.sv
// Rebuilds a level from rising/falling edge pulses with a minimum hold time and a
// one-deep pending slot. Define EDGE_TO_LEVEL_STATS_EN to add change/error counters.
module edge_to_level
   import edge_pkg::*;
#(
   parameter int MIN_HOLD = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic p_edge,
   input  logic n_edge,
   output logic level,
   output logic change,
   output logic busy,
   output logic err_conflict,
   output logic err_redundant
`ifdef EDGE_TO_LEVEL_STATS_EN
   ,
   output logic [STAT_CHANGE_W-1:0] change_count,
   output logic [STAT_ERR_W-1:0]    err_count
`endif
);

   localparam int CW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
   localparam logic [CW-1:0] HOLD_LOAD = CW'(MIN_HOLD - 1);

   if (MIN_HOLD < 1) begin : g_bad_min_hold
      $error("edge_to_level: MIN_HOLD must be at least 1");
   end

   state_t state_q, state_d;
   logic   pending_q, pending_d;
   logic   change_q, change_d;
   logic   err_conflict_q, err_conflict_d;
   logic   err_redundant_q, err_redundant_d;

   logic cur_level;
   logic tgt;
   logic conflict;
   logic req_valid;
   logic req_redundant;
   logic req_toggle;
   logic eff_pending;
   logic timer_load;
   logic timer_en;
   logic timer_expired;

   hold_timer #(
      .CW (CW)
   ) u_hold_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (timer_load),
      .load_val (HOLD_LOAD),
      .en       (timer_en),
      .expired  (timer_expired)
   );

   // A single edge either confirms the target (redundant) or toggles the pending slot.
   always_comb begin
      cur_level     = level_of(state_q);
      tgt           = pending_q ? ~cur_level : cur_level;
      conflict      = p_edge & n_edge;
      req_valid     = p_edge ^ n_edge;
      req_redundant = req_valid && (p_edge == tgt);
      req_toggle    = req_valid && (p_edge != tgt);
      eff_pending   = pending_q ^ req_toggle;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= S_LOW;
         pending_q       <= 1'b0;
         change_q        <= 1'b0;
         err_conflict_q  <= 1'b0;
         err_redundant_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         pending_q       <= pending_d;
         change_q        <= change_d;
         err_conflict_q  <= err_conflict_d;
         err_redundant_q <= err_redundant_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      pending_d       = pending_q;
      change_d        = 1'b0;
      err_conflict_d  = conflict;
      err_redundant_d = req_redundant;
      timer_load      = 1'b0;
      timer_en        = is_hold(state_q);
      unique case (state_q)
         S_LOW, S_HIGH: begin
            pending_d = 1'b0;
            if (req_toggle) begin
               state_d    = hold_state(~cur_level);
               timer_load = 1'b1;
               change_d   = 1'b1;
            end
         end
         S_LOW_HOLD, S_HIGH_HOLD: begin
            if (!timer_expired) begin
               pending_d = eff_pending;
            end else if (eff_pending) begin
               state_d    = hold_state(~cur_level);
               timer_load = 1'b1;
               change_d   = 1'b1;
               pending_d  = 1'b0;
            end else begin
               state_d   = stable_state(cur_level);
               pending_d = 1'b0;
            end
         end
         default: begin
            state_d   = S_LOW;
            pending_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      level         = level_of(state_q);
      busy          = is_hold(state_q);
      change        = change_q;
      err_conflict  = err_conflict_q;
      err_redundant = err_redundant_q;
   end

`ifdef EDGE_TO_LEVEL_STATS_EN
   logic [STAT_CHANGE_W-1:0] change_cnt_q, change_cnt_d;
   logic [STAT_ERR_W-1:0]    err_cnt_q, err_cnt_d;

   // Both counters saturate; simultaneous errors count once.
   always_comb begin
      change_cnt_d = change_cnt_q;
      err_cnt_d    = err_cnt_q;
      if (change_q && (change_cnt_q != '1)) begin
         change_cnt_d = change_cnt_q + STAT_CHANGE_W'(1);
      end
      if ((err_conflict_q || err_redundant_q) && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + STAT_ERR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         change_cnt_q <= '0;
         err_cnt_q    <= '0;
      end else begin
         change_cnt_q <= change_cnt_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign change_count = change_cnt_q;
   assign err_count    = err_cnt_q;
`endif

endmodule

// File: tb/tb_edge_to_level.sv
// Scoreboard bench for edge_to_level with MIN_HOLD = 4: a behavioural model pushes
// the expected output vector per driven cycle, popped and compared after the edge.
module tb_edge_to_level;

   localparam int MIN_HOLD = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic p_edge = 1'b0;
   logic n_edge = 1'b0;
   logic level, change, busy, err_conflict, err_redundant;
`ifdef EDGE_TO_LEVEL_STATS_EN
   logic [15:0] change_count;
   logic [7:0]  err_count;
`endif

   always #5 clk = ~clk;

   edge_to_level #(
      .MIN_HOLD (MIN_HOLD)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .p_edge        (p_edge),
      .n_edge        (n_edge),
      .level         (level),
      .change        (change),
      .busy          (busy),
      .err_conflict  (err_conflict),
      .err_redundant (err_redundant)
`ifdef EDGE_TO_LEVEL_STATS_EN
      ,
      .change_count  (change_count),
      .err_count     (err_count)
`endif
   );

   int    checks = 0;
   int    failures = 0;
   string cur_tag = "init";
   logic [4:0] sb[$];

   // Reference model state
   bit m_level, m_pending, m_busy;
   int m_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Returns {level, change, busy, err_conflict, err_redundant} after this cycle.
   function automatic logic [4:0] model_step(input bit p, input bit n, input bit r);
      bit conf, valid, tgt, red, tog, chg, effp;
      chg = 1'b0;
      conf = 1'b0;
      red = 1'b0;
      if (r) begin
         m_level = 1'b0;
         m_pending = 1'b0;
         m_busy = 1'b0;
         m_cnt = 0;
      end else begin
         conf  = p && n;
         valid = p ^ n;
         tgt   = m_pending ? !m_level : m_level;
         red   = valid && (p == tgt);
         tog   = valid && (p != tgt);
         if (!m_busy) begin
            if (tog) begin
               m_level = !m_level;
               chg = 1'b1;
               m_busy = 1'b1;
               m_cnt = MIN_HOLD - 1;
            end
         end else if (m_cnt > 0) begin
            m_cnt--;
            if (tog) m_pending = !m_pending;
         end else begin
            effp = m_pending ^ tog;
            m_pending = 1'b0;
            if (effp) begin
               m_level = !m_level;
               chg = 1'b1;
               m_cnt = MIN_HOLD - 1;
            end else begin
               m_busy = 1'b0;
            end
         end
      end
      return {m_level, chg, m_busy, conf, red};
   endfunction

   task automatic step(input bit p, input bit n, input bit r);
      logic [4:0] got, exp;
      @(negedge clk);
      p_edge = p;
      n_edge = n;
      reset  = r;
      sb.push_back(model_step(p, n, r));
      @(posedge clk);
      #1;
      got = {level, change, busy, err_conflict, err_redundant};
      if (sb.size() == 0) begin
         check({cur_tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         exp = sb.pop_front();
         check(cur_tag, {27'd0, got}, {27'd0, exp});
      end
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      idle(2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      cur_tag = "reset";
      do_reset();
      check("reset_out", {level, change, busy, err_conflict, err_redundant}, 5'b00000);

      // 1: basic rise and hold window
      cur_tag = "t1";
      step(1'b1, 1'b0, 1'b0);
      check("t1_rise", {level, change, busy}, 3'b111);
      idle(3);
      check("t1_busy_last", {level, change, busy}, 3'b101);
      idle(1);
      check("t1_idle", {level, busy}, 2'b10);

      // 2: queued fall applies MIN_HOLD cycles after the rise
      cur_tag = "t2";
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      idle(1);
      step(1'b0, 1'b1, 1'b0);
      idle(1);
      check("t2_pending_hold", {level, change}, 2'b10);
      idle(1);
      check("t2_fall", {level, change, busy}, 3'b011);
      idle(3);
      check("t2_busy18", {level, busy}, 2'b01);
      idle(1);
      check("t2_idle19", {level, busy}, 2'b00);

      // 3: cancel the pending change
      cur_tag = "t3";
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      idle(1);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      check("t3_no_err", {err_conflict, err_redundant}, 2'b00);
      idle(1);
      check("t3_cancel", {level, change, busy, err_conflict, err_redundant}, 5'b10000);
      idle(6);

      // 4: conflict while low
      cur_tag = "t4";
      do_reset();
      step(1'b1, 1'b1, 1'b0);
      check("t4_conflict", {err_conflict, level, busy, change}, 4'b1000);
      idle(1);
      check("t4_pulse_end", {err_conflict, level}, 2'b00);

      // 5: redundant edge when stable and during hold
      cur_tag = "t5";
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      idle(8);
      step(1'b1, 1'b0, 1'b0);
      check("t5_redundant_stable", {err_redundant, level, change}, 3'b110);
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      idle(1);
      step(1'b1, 1'b0, 1'b0);
      check("t5_redundant_hold", {err_redundant, level, busy}, 3'b111);

      // 6: reset with a change pending
      cur_tag = "t6";
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      idle(1);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      check("t6_reset", {level, busy, change}, 3'b000);
      idle(1);
      check("t6_no_change", {level, change}, 2'b00);
      step(1'b1, 1'b0, 1'b0);
      check("t6_pending_clear", {level, change, err_redundant}, 3'b110);
      idle(5);

      // Random traffic against the model
      cur_tag = "rand";
      do_reset();
      for (int i = 0; i < 800; i++) begin
         int unsigned r;
         r = $urandom_range(0, 199);
         if (r < 30)       step(1'b1, 1'b0, 1'b0);
         else if (r < 60)  step(1'b0, 1'b1, 1'b0);
         else if (r < 66)  step(1'b1, 1'b1, 1'b0);
         else if (r == 199) step(1'b0, 1'b0, 1'b1);
         else              step(1'b0, 1'b0, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
